// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the bridge FSM state encoding, the default bus widths and timeout
// depth, and a helper that sizes the optional timeout counter.
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W_DEF       = 32;
  localparam int unsigned APB_DATA_W_DEF       = 32;
  localparam int unsigned APB_TIMEOUT_CYC_DEF  = 16;

  // IDLE   : waiting for a command, req_ready high
  // SETUP  : psel=1, penable=0 for a single cycle
  // ACCESS : psel=1, penable=1 until pready (or timeout)
  // RESP   : rsp_valid=1 until rsp_ready
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Width needed to hold values 0..limit; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter for the APB master bridge.
// Latency: expire is combinational from the count and inc in the same cycle.
// Backpressure: none; the owner FSM decides when to clear and increment.
//
// Ports:
//   pclk, reset : clock and synchronous active-high reset
//   clear       : zero the count (asserted in the cycle before ACCESS)
//   inc         : one ACCESS cycle elapsed with pready low
//   expire      : this increment brings the count to LIMIT
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = APB_TIMEOUT_CYC_DEF
) (
  input  logic pclk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CNT_W = cnt_width(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Firing on the increment that would reach LIMIT lets the FSM leave ACCESS
  // after exactly LIMIT stalled cycles without a redundant extra state.
  assign expire = inc && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge, one transfer in flight.
// Latency: handshake -> SETUP next cycle, ACCESS after that, rsp_valid one
//          cycle after the pready cycle (3 cycles minimum).
// Backpressure: req_ready only in IDLE; RESP holds until rsp_ready.
//
// Ports:
//   pclk, reset                  : clock, synchronous active-high reset
//   req_valid/req_ready          : command handshake
//   req_write/req_addr/req_wdata : command fields, sampled on handshake
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata/rsp_err            : read data (0 for writes) and error flag
//   psel/penable/pwrite/paddr/pwdata : registered APB request
//   prdata/pready/pslverr        : APB completion, looked at only in ACCESS
//
// Build option: define APB_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES
// stalled cycles; a timeout completes with rsp_err=1 and rsp_rdata=0.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W         = APB_DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYC_DEF
) (
  input  logic              pclk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A zero timeout would make ACCESS complete before the slave is sampled.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e        state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_inc;

  // SETUP is the only way into ACCESS, so clearing there restarts the count
  // for every transfer.
  assign tmo_clear = (state_q == SETUP);
  assign tmo_inc   = (state_q == ACCESS) && !pready;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .pclk   (pclk),
    .reset  (reset),
    .clear  (tmo_clear),
    .inc    (tmo_inc),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = SETUP;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        // pready wins over a timeout landing in the same cycle.
        if (pready) begin
          state_d     = RESP;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // APB control and rsp_valid are decoded from the next state so they
    // come straight out of flops, aligned with the state they describe.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge.
// Latency: n/a.
// Backpressure: exercised via rsp_ready hold and slave wait states.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 2ns after the edge.
  task automatic step();
    @(posedge pclk);
    #2;
  endtask

  // One complete transfer from IDLE: wait states in ACCESS, then the response
  // held for 'hold' cycles with rsp_ready low before it is accepted.
  task automatic run_xfer(input string nm, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int waits,
                          input logic [DW-1:0] rd, input logic err, input int hold);
    logic [DW-1:0] exp_rd;
    exp_rd    = wr ? '0 : rd;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    step();
    // SETUP; garbage on the completion inputs must be ignored here.
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    check_eq({nm, "_setup_psel"}, psel, 1'b1);
    check_eq({nm, "_setup_penable"}, penable, 1'b0);
    check_eq({nm, "_setup_paddr"}, paddr, addr);
    check_eq({nm, "_setup_pwrite"}, pwrite, wr);
    check_eq({nm, "_setup_pwdata"}, pwdata, wdata);
    check_eq({nm, "_setup_req_ready"}, req_ready, 1'b0);
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = ~rd;
    step();
    for (int i = 0; i <= waits; i++) begin
      check_eq({nm, "_access_psel"}, psel, 1'b1);
      check_eq({nm, "_access_penable"}, penable, 1'b1);
      check_eq({nm, "_access_paddr"}, paddr, addr);
      check_eq({nm, "_access_pwdata"}, pwdata, wdata);
      check_eq({nm, "_access_rsp_valid"}, rsp_valid, 1'b0);
      pready  = (i == waits);
      pslverr = (i == waits) ? err : 1'b1;
      prdata  = (i == waits) ? rd : ~rd;
      step();
    end
    pready  = 1'b1;
    pslverr = ~err;
    prdata  = 32'hBAD0_BAD0;
    for (int j = 0; j <= hold; j++) begin
      check_eq({nm, "_resp_valid"}, rsp_valid, 1'b1);
      check_eq({nm, "_resp_psel"}, psel, 1'b0);
      check_eq({nm, "_resp_penable"}, penable, 1'b0);
      check_eq({nm, "_resp_rdata"}, rsp_rdata, exp_rd);
      check_eq({nm, "_resp_err"}, rsp_err, err);
      check_eq({nm, "_resp_req_ready"}, req_ready, 1'b0);
      rsp_ready = (j == hold);
      step();
    end
    rsp_ready = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    check_eq({nm, "_done_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({nm, "_done_req_ready"}, req_ready, 1'b1);
    check_eq({nm, "_done_psel"}, psel, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h1234_5678;
    req_wdata = 32'h9ABC_DEF0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    step();
    step();
    check_eq("rst_psel", psel, 1'b0);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_pwrite", pwrite, 1'b0);
    check_eq("rst_paddr", paddr, 32'h0);
    check_eq("rst_pwdata", pwdata, 32'h0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_req_ready", req_ready, 1'b1);
    reset = 1'b0;

    // No request: bus stays quiet even with completion inputs wiggling.
    for (int i = 0; i < 3; i++) begin
      pready  = i[0];
      pslverr = 1'b1;
      step();
      check_eq("idle_psel", psel, 1'b0);
      check_eq("idle_req_ready", req_ready, 1'b1);
      check_eq("idle_rsp_valid", rsp_valid, 1'b0);
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    // Write, zero wait states; read data must come back as 0.
    run_xfer("wr0", 1'b1, 32'h0, 32'h55, 0, 32'hDEAD_BEEF, 1'b0, 0);
    // Read with three wait states.
    run_xfer("rd3", 1'b0, 32'h4, 32'h0, 3, 32'h7FF, 1'b0, 0);
    // Read with slave error; response held five cycles.
    run_xfer("rderr", 1'b0, 32'h8, 32'h0, 1, 32'hCAFE_0001, 1'b1, 5);

    // Reset in the middle of ACCESS abandons the transfer.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h77;
    step();
    req_valid = 1'b0;
    pready    = 1'b0;
    step();
    check_eq("rstacc_penable_before", penable, 1'b1);
    reset = 1'b1;
    step();
    check_eq("rstacc_psel", psel, 1'b0);
    check_eq("rstacc_penable", penable, 1'b0);
    check_eq("rstacc_req_ready", req_ready, 1'b1);
    check_eq("rstacc_rsp_valid", rsp_valid, 1'b0);
    check_eq("rstacc_paddr", paddr, 32'h0);
    reset  = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rstacc_after_rsp_valid", rsp_valid, 1'b0);
      check_eq("rstacc_after_psel", psel, 1'b0);
    end
    pready = 1'b0;

    // Back-to-back reads: cycle 0 is IDLE, so handshakes land at 0,4,8,12.
    req_valid = 1'b1;
    req_write = 1'b0;
    rsp_ready = 1'b1;
    pready    = 1'b1;
    pslverr   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int ph;
      int h;
      ph = i % 4;
      h  = ((i + 3) / 4) * 4 - 4;
      check_eq("b2b_req_ready", req_ready, ph == 0);
      check_eq("b2b_psel", psel, (ph == 1) || (ph == 2));
      check_eq("b2b_penable", penable, ph == 2);
      check_eq("b2b_rsp_valid", rsp_valid, ph == 3);
      if (ph == 1 || ph == 2) check_eq("b2b_paddr", paddr, 32'h100 + 4 * h);
      if (ph == 3) check_eq("b2b_rdata", rsp_rdata, 32'hA000 + i - 1);
      req_addr = 32'h100 + 4 * i;
      prdata   = 32'hA000 + i;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    check_eq("b2b_stop_psel", psel, 1'b0);
    check_eq("b2b_stop_req_ready", req_ready, 1'b1);

`ifdef APB_TIMEOUT_EN
    // pready ready on the 16th ACCESS cycle still completes normally.
    run_xfer("tmo_edge", 1'b0, 32'hC, 32'h0, 15, 32'h1234, 1'b0, 0);
    // pready stuck low: 16 ACCESS cycles, then an error response.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    step();
    req_valid = 1'b0;
    pready    = 1'b0;
    prdata    = 32'h5555_AAAA;
    step();
    for (int i = 0; i < 16; i++) begin
      check_eq("tmo_penable", penable, 1'b1);
      check_eq("tmo_rsp_valid_early", rsp_valid, 1'b0);
      step();
    end
    check_eq("tmo_rsp_valid", rsp_valid, 1'b1);
    check_eq("tmo_rsp_err", rsp_err, 1'b1);
    check_eq("tmo_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("tmo_psel", psel, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("tmo_done_req_ready", req_ready, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
